// File: rtl/hazard_ctrl_if.sv
// Control bundle between the hazard controller and the pipeline registers.
// The controller drives the master side; the pipeline registers and fetch use slave.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       rs1_id;
   logic [4:0]       rs2_id;
   logic             use_rs1_id;
   logic             use_rs2_id;
   logic [4:0]       rd_ex;
   logic             memtoreg_ex;
   logic             mispredict_ex;
   logic [31:0]      target_pc_ex;
   logic             mem_busy;
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_en;
   logic             id_ex_flush;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      input  rs1_id, rs2_id, use_rs1_id, use_rs2_id,
      input  rd_ex, memtoreg_ex, mispredict_ex,
      input  target_pc_ex, mem_busy,
      output pc_en, if_id_en, if_id_flush,
      output id_ex_en, id_ex_flush,
      output redirect_valid, redirect_pc,
      output stall_cnt, flush_cnt
   );

   modport slave (
      output rs1_id, rs2_id, use_rs1_id, use_rs2_id,
      output rd_ex, memtoreg_ex, mispredict_ex,
      output target_pc_ex, mem_busy,
      input  pc_en, if_id_en, if_id_flush,
      input  id_ex_en, id_ex_flush,
      input  redirect_valid, redirect_pc,
      input  stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory freezes,
// mispredict flush/redirect with deferred issue, saturating event counters.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input logic           clk,
   input logic           rst,
   hazard_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_RUN,
      S_FREEZE,
      S_FLUSH
   } state_t;

   localparam logic [1:0] FC_M1 = 2'(FLUSH_CYCLES - 1);

   state_t      r_state, w_state_nx;
   logic        r_pend, w_pend_nx;
   logic [31:0] r_pend_pc, w_pend_pc_nx;
   logic [1:0]  r_fcnt, w_fcnt_nx;

   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_lu;
   logic w_hit1;
   logic w_hit2;
   logic w_want_redir;
   logic w_do_freeze;
   logic w_do_flush;
   logic w_do_redir;
   logic w_do_stall;

   assign w_hit1 = bus.use_rs1_id
                   && (bus.rs1_id == bus.rd_ex);
   assign w_hit2 = bus.use_rs2_id
                   && (bus.rs2_id == bus.rd_ex);
   assign w_lu   = bus.memtoreg_ex
                   && (bus.rd_ex != 5'd0)
                   && (w_hit1 || w_hit2);

   assign w_want_redir = bus.mispredict_ex || r_pend;

   // Classify the cycle; fcnt survives a freeze so an interrupted flush resumes.
   always_comb begin
      w_do_freeze = 1'b0;
      w_do_flush  = 1'b0;
      w_do_redir  = 1'b0;
      w_do_stall  = 1'b0;
      if (!rst) begin
         if (bus.mem_busy) begin
            w_do_freeze = 1'b1;
         end else begin
            unique case (r_state)
               S_FLUSH: w_do_flush = 1'b1;
               S_FREEZE: begin
                  if (r_fcnt != 2'd0)
                     w_do_flush = 1'b1;
                  else if (w_want_redir)
                     w_do_redir = 1'b1;
                  else if (w_lu)
                     w_do_stall = 1'b1;
               end
               default: begin
                  if (w_want_redir)
                     w_do_redir = 1'b1;
                  else if (w_lu)
                     w_do_stall = 1'b1;
               end
            endcase
         end
      end
   end

   always_comb begin
      w_state_nx         = r_state;
      w_pend_nx          = r_pend;
      w_pend_pc_nx       = r_pend_pc;
      w_fcnt_nx          = r_fcnt;
      bus.pc_en          = 1'b1;
      bus.if_id_en       = 1'b1;
      bus.if_id_flush    = 1'b0;
      bus.id_ex_en       = 1'b1;
      bus.id_ex_flush    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      if (w_do_freeze) begin
         bus.pc_en    = 1'b0;
         bus.if_id_en = 1'b0;
         bus.id_ex_en = 1'b0;
         w_state_nx   = S_FREEZE;
         if (bus.mispredict_ex) begin
            w_pend_nx    = 1'b1;
            w_pend_pc_nx = bus.target_pc_ex;
         end
      end else if (w_do_flush) begin
         bus.if_id_flush = 1'b1;
         bus.id_ex_flush = 1'b1;
         if (r_fcnt <= 2'd1) begin
            w_fcnt_nx  = 2'd0;
            w_state_nx = S_RUN;
         end else begin
            w_fcnt_nx  = r_fcnt - 2'd1;
            w_state_nx = S_FLUSH;
         end
      end else if (w_do_redir) begin
         bus.redirect_valid = 1'b1;
         bus.redirect_pc    = bus.mispredict_ex
                              ? bus.target_pc_ex
                              : r_pend_pc;
         bus.if_id_flush    = 1'b1;
         bus.id_ex_flush    = 1'b1;
         w_pend_nx          = 1'b0;
         if (FLUSH_CYCLES > 1) begin
            w_state_nx = S_FLUSH;
            w_fcnt_nx  = FC_M1;
         end else begin
            w_state_nx = S_RUN;
         end
      end else if (w_do_stall) begin
         bus.pc_en       = 1'b0;
         bus.if_id_en    = 1'b0;
         bus.id_ex_flush = 1'b1;
         w_state_nx      = S_RUN;
      end else begin
         w_state_nx = S_RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_RUN;
         r_pend    <= 1'b0;
         r_pend_pc <= 32'd0;
         r_fcnt    <= 2'd0;
      end else begin
         r_state   <= w_state_nx;
         r_pend    <= w_pend_nx;
         r_pend_pc <= w_pend_pc_nx;
         r_fcnt    <= w_fcnt_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if ((w_do_freeze || w_do_stall)
             && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_do_redir && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;

endmodule
